// File: rtl/mips_dmem_arbiter.sv
// Arbiter that shares one single-port word-addressed data RAM between the core data port and a host port.
// The CPU has priority. A starvation counter forces a host grant after STARVE_LIMIT CPU wins in a row.
module mips_dmem_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        CpuMemRead,
  input  logic [1:0]        CpuMemWrite,
  input  logic [31:0]       CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic [DATA_W-1:0] CpuRData,
  output logic              CpuStall,
  input  logic              HostReq,
  input  logic              HostWe,
  input  logic [31:0]       HostAddr,
  input  logic [DATA_W-1:0] HostWData,
  output logic [DATA_W-1:0] HostRData,
  output logic              HostAck,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamWData,
  output logic              RamRe,
  output logic              RamWe,
  input  logic [DATA_W-1:0] RamRData,
  output logic              ErrFlag
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_host_q, owner_host_d;
  logic                op_rd_q, op_rd_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_re_q, ram_re_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                host_ack_q, host_ack_d;
  logic                err_q, err_d;

  logic                cpu_rd_c, cpu_wr_c, cpu_req_c, cpu_bad_c;
  logic                starved_c, host_win_c, cpu_win_c, any_req_c, lat_done_c;
  logic [ADDR_W-1:0]   sel_word_c;
  logic [DATA_W-1:0]   sel_wdata_c;
  logic                sel_rd_c, sel_mis_c;

  // Address bits above the RAM depth are deliberately dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{CpuAddr[31:ADDR_W+2], HostAddr[31:ADDR_W+2]};

  // Request decode and arbitration; the result is only acted on in IDLE.
  always_comb begin
    cpu_rd_c    = (CpuMemRead == 2'b11) && (CpuMemWrite == 2'b00);
    cpu_wr_c    = (CpuMemRead == 2'b00) && (CpuMemWrite == 2'b11);
    cpu_req_c   = cpu_rd_c || cpu_wr_c;
    cpu_bad_c   = !cpu_req_c && ((CpuMemRead != 2'b00) || (CpuMemWrite != 2'b00));
    starved_c   = (starve_q == STARVE_W'(STARVE_LIMIT));
    host_win_c  = HostReq && (!cpu_req_c || starved_c);
    cpu_win_c   = cpu_req_c && !host_win_c;
    any_req_c   = cpu_req_c || HostReq;
    sel_word_c  = host_win_c ? HostAddr[ADDR_W+1:2] : CpuAddr[ADDR_W+1:2];
    sel_mis_c   = host_win_c ? (HostAddr[1:0] != 2'b00) : (CpuAddr[1:0] != 2'b00);
    sel_wdata_c = host_win_c ? HostWData : CpuWData;
    sel_rd_c    = host_win_c ? !HostWe : cpu_rd_c;
    lat_done_c  = (wait_cnt_q == CNT_W'(MEM_LAT - 1));
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      owner_host_q <= 1'b0;
      op_rd_q      <= 1'b0;
      starve_q     <= '0;
      wait_cnt_q   <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      host_ack_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_host_q <= owner_host_d;
      op_rd_q      <= op_rd_d;
      starve_q     <= starve_d;
      wait_cnt_q   <= wait_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_re_q     <= ram_re_d;
      ram_we_q     <= ram_we_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = op_rd_q ? ST_WAIT : ST_ACK;
      ST_WAIT:  if (lat_done_c) state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    owner_host_d = owner_host_q;
    op_rd_d      = op_rd_q;
    starve_d     = starve_q;
    wait_cnt_d   = '0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_re_d     = 1'b0;
    ram_we_d     = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    host_ack_d   = 1'b0;
    err_d        = err_q || cpu_bad_c;
    case (state_q)
      ST_IDLE: begin
        if (!HostReq || host_win_c) begin
          starve_d = '0;
        end else if (cpu_win_c && !starved_c) begin
          starve_d = starve_q + STARVE_W'(1);
        end
        if (any_req_c) begin
          owner_host_d = host_win_c;
          op_rd_d      = sel_rd_c;
          ram_addr_d   = sel_word_c;
          ram_wdata_d  = sel_wdata_c;
          ram_re_d     = sel_rd_c;
          ram_we_d     = !sel_rd_c;
          if (sel_mis_c) err_d = 1'b1;
        end
      end
      ST_ISSUE: host_ack_d = owner_host_q && !op_rd_q;
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (lat_done_c) begin
          host_ack_d = owner_host_q;
          if (owner_host_q) host_rdata_d = RamRData;
          else              cpu_rdata_d  = RamRData;
        end
      end
      default: ;
    endcase
  end

  // Stall releases only in the CPU's own ACK cycle so the core advances exactly once.
  assign CpuStall  = !Reset && cpu_req_c && !((state_q == ST_ACK) && !owner_host_q);
  assign CpuRData  = cpu_rdata_q;
  assign HostRData = host_rdata_q;
  assign HostAck   = host_ack_q;
  assign RamAddr   = ram_addr_q;
  assign RamWData  = ram_wdata_q;
  assign RamRe     = ram_re_q;
  assign RamWe     = ram_we_q;
  assign ErrFlag   = err_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Directed bench for mips_dmem_arbiter with a behavioural single-port RAM of MEM_LAT read latency.
module tb_mips_dmem_arbiter;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 1;

  logic              Clk;
  logic              Reset;
  logic [1:0]        CpuMemRead, CpuMemWrite;
  logic [31:0]       CpuAddr;
  logic [DATA_W-1:0] CpuWData, CpuRData;
  logic              CpuStall;
  logic              HostReq, HostWe, HostAck;
  logic [31:0]       HostAddr;
  logic [DATA_W-1:0] HostWData, HostRData;
  logic [ADDR_W-1:0] RamAddr;
  logic [DATA_W-1:0] RamWData, RamRData;
  logic              RamRe, RamWe, ErrFlag;
  logic              preload;

  int checks = 0;
  int errors = 0;

  mips_dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(4)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .CpuMemRead(CpuMemRead), .CpuMemWrite(CpuMemWrite), .CpuAddr(CpuAddr),
    .CpuWData(CpuWData), .CpuRData(CpuRData), .CpuStall(CpuStall),
    .HostReq(HostReq), .HostWe(HostWe), .HostAddr(HostAddr), .HostWData(HostWData),
    .HostRData(HostRData), .HostAck(HostAck),
    .RamAddr(RamAddr), .RamWData(RamWData), .RamRe(RamRe), .RamWe(RamWe),
    .RamRData(RamRData), .ErrFlag(ErrFlag)
  );

  always #5 Clk = ~Clk;

  // RAM model; off-cycle read data is poisoned so a mistimed capture is visible.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_pipe [MEM_LAT];
  always @(posedge Clk) begin
    if (preload) mem[0] <= 32'h1234_5678;
    if (RamWe) mem[RamAddr] <= RamWData;
    rd_pipe[0] <= RamRe ? mem[RamAddr] : 32'hBAD0_BAD0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign RamRData = rd_pipe[MEM_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_access(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                            output int stall_n, output int re_n, output int we_n,
                            output logic [ADDR_W-1:0] addr_seen, output logic [31:0] rdata);
    stall_n = 0; re_n = 0; we_n = 0; addr_seen = '1;
    @(negedge Clk);
    CpuMemRead  = rd ? 2'b11 : 2'b00;
    CpuMemWrite = rd ? 2'b00 : 2'b11;
    CpuAddr     = addr;
    CpuWData    = wdata;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (RamRe) re_n++;
      if (RamWe) we_n++;
      if (RamRe || RamWe) addr_seen = RamAddr;
      if (!CpuStall) break;
      stall_n++;
      @(negedge Clk);
    end
    rdata       = CpuRData;
    CpuMemRead  = 2'b00;
    CpuMemWrite = 2'b00;
  endtask

  task automatic host_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output int ack_n, output logic [31:0] rdata);
    @(negedge Clk);
    HostReq = 1'b1; HostWe = we; HostAddr = addr; HostWData = wdata;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (HostAck) break;
      lat++;
      @(negedge Clk);
    end
    rdata   = HostRData;
    ack_n   = HostAck ? 1 : 0;
    HostReq = 1'b0;
    @(negedge Clk);
    #1;
    if (HostAck) ack_n++;
  endtask

  // CPU repeats one access n_cpu times back to back while the host holds one request.
  task automatic run_mixed(input int n_cpu, input logic cpu_rd, input logic [31:0] cpu_addr,
                           input logic [31:0] cpu_wdata, input logic host_we,
                           input logic [31:0] host_addr, input logic [31:0] host_wdata,
                           output int cycles, output int host_at,
                           output logic [31:0] cpu_rdata, output logic [31:0] host_rdata);
    int   done;
    logic host_done;
    done = 0; host_done = 1'b0; host_at = -1; cycles = 0;
    cpu_rdata = '0; host_rdata = '0;
    @(negedge Clk);
    HostReq = 1'b1; HostWe = host_we; HostAddr = host_addr; HostWData = host_wdata;
    for (int i = 0; i < 200 && !(done == n_cpu && host_done); i++) begin
      CpuMemRead  = (done < n_cpu && cpu_rd)  ? 2'b11 : 2'b00;
      CpuMemWrite = (done < n_cpu && !cpu_rd) ? 2'b11 : 2'b00;
      CpuAddr     = cpu_addr;
      CpuWData    = cpu_wdata;
      #1;
      cycles++;
      if (done < n_cpu && !CpuStall) begin
        done++;
        cpu_rdata = CpuRData;
      end
      if (HostAck && !host_done) begin
        host_done  = 1'b1;
        host_at    = done;
        host_rdata = HostRData;
        HostReq    = 1'b0;
      end
      @(negedge Clk);
    end
    CpuMemRead = 2'b00; CpuMemWrite = 2'b00; HostReq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_n, re_n, we_n, lat, ack_n, cycles, host_at, strobes;
    logic [ADDR_W-1:0] aseen;
    logic [31:0] rdata, rdata2;

    Clk = 1'b0; Reset = 1'b1; preload = 1'b1;
    CpuMemRead = 2'b00; CpuMemWrite = 2'b00; CpuAddr = '0; CpuWData = '0;
    HostReq = 1'b0; HostWe = 1'b0; HostAddr = '0; HostWData = '0;
    repeat (2) @(negedge Clk);
    #1;
    check("rst_ram_re", 32'(RamRe), 32'd0);
    check("rst_ram_we", 32'(RamWe), 32'd0);
    check("rst_ram_addr", 32'(RamAddr), 32'd0);
    check("rst_host_ack", 32'(HostAck), 32'd0);
    check("rst_err", 32'(ErrFlag), 32'd0);
    check("rst_stall", 32'(CpuStall), 32'd0);
    Reset = 1'b0; preload = 1'b0;

    // CPU write then read back
    cpu_access(1'b0, 32'h10, 32'hDEAD_BEEF, stall_n, re_n, we_n, aseen, rdata);
    check("wr_stall_cycles", 32'(stall_n), 32'd2);
    check("wr_we_cycles", 32'(we_n), 32'd1);
    check("wr_re_cycles", 32'(re_n), 32'd0);
    check("wr_ram_addr", 32'(aseen), 32'd4);
    check("wr_mem4", mem[4], 32'hDEAD_BEEF);
    cpu_access(1'b1, 32'h10, 32'h0, stall_n, re_n, we_n, aseen, rdata);
    check("rd_stall_cycles", 32'(stall_n), 32'd3);
    check("rd_re_cycles", 32'(re_n), 32'd1);
    check("rd_data", rdata, 32'hDEAD_BEEF);

    // Host read of preloaded word
    host_access(1'b0, 32'h0, 32'h0, lat, ack_n, rdata);
    check("host_rd_latency", 32'(lat), 32'd3);
    check("host_ack_pulses", 32'(ack_n), 32'd1);
    check("host_rd_data", rdata, 32'h1234_5678);

    // Starvation bound: host wins the fifth arbitration
    run_mixed(6, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, cycles, host_at, rdata, rdata2);
    check("starve_host_after", 32'(host_at), 32'd4);
    check("starve_cycles", 32'(cycles), 32'd28);
    check("starve_cpu_data", rdata, 32'hDEAD_BEEF);
    check("starve_host_data", rdata2, 32'h1234_5678);

    // Simultaneous writes to the same word: CPU first, host data lands last
    run_mixed(1, 1'b0, 32'h20, 32'h1111_2222, 1'b1, 32'h20, 32'hCAFE_F00D, cycles, host_at, rdata, rdata2);
    check("tie_host_after", 32'(host_at), 32'd1);
    check("tie_cycles", 32'(cycles), 32'd6);
    check("tie_mem8", mem[8], 32'hCAFE_F00D);
    cpu_access(1'b1, 32'h20, 32'h0, stall_n, re_n, we_n, aseen, rdata);
    check("tie_readback", rdata, 32'hCAFE_F00D);
    check("err_clean", 32'(ErrFlag), 32'd0);

    // Illegal encoding: no access, no stall, sticky error
    @(negedge Clk);
    CpuMemRead = 2'b01; CpuMemWrite = 2'b00;
    #1;
    check("bad_enc_stall", 32'(CpuStall), 32'd0);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      if (RamRe || RamWe) strobes++;
    end
    check("bad_enc_strobes", 32'(strobes), 32'd0);
    check("bad_enc_err", 32'(ErrFlag), 32'd1);
    CpuMemRead = 2'b00;
    Reset = 1'b1;
    @(negedge Clk); #1;
    Reset = 1'b0;
    check("err_cleared_by_reset", 32'(ErrFlag), 32'd0);

    // Misaligned address beyond depth wraps to word 0
    cpu_access(1'b1, 32'h1002, 32'h0, stall_n, re_n, we_n, aseen, rdata);
    check("wrap_ram_addr", 32'(aseen), 32'd0);
    check("wrap_data", rdata, 32'h1234_5678);
    check("wrap_err", 32'(ErrFlag), 32'd1);

    // Reset during WAIT of a host read abandons it
    @(negedge Clk);
    HostReq = 1'b1; HostWe = 1'b0; HostAddr = 32'h0;
    @(negedge Clk); #1;
    check("rst_mid_issue_re", 32'(RamRe), 32'd1);
    @(negedge Clk);
    Reset = 1'b1; HostReq = 1'b0;
    @(negedge Clk); #1;
    check("rst_mid_ack", 32'(HostAck), 32'd0);
    check("rst_mid_re", 32'(RamRe), 32'd0);
    check("rst_mid_host_rdata", HostRData, 32'd0);
    check("rst_mid_cpu_rdata", CpuRData, 32'd0);
    check("rst_mid_err", 32'(ErrFlag), 32'd0);
    Reset = 1'b0;
    ack_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); #1;
      if (HostAck) ack_n++;
    end
    check("rst_mid_no_ack", 32'(ack_n), 32'd0);
    cpu_access(1'b1, 32'h10, 32'h0, stall_n, re_n, we_n, aseen, rdata);
    check("post_rst_stall", 32'(stall_n), 32'd3);
    check("post_rst_data", rdata, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
